// File: rtl/alu_pkg.sv
// Shared ALU op-code encodings, ZCNV flag bit positions and the op-code
// legality check used by the operand-issue stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        XOR = 4'b1000,
        OR  = 4'b1100,
        AND = 4'b1110
    } alu_op_e;

    localparam int Z_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int V_BIT = 0;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ADD, SUB, XOR, OR, AND: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two operand read ports, one debug read port,
// one synchronous write port. Register r0 always reads as zero.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [RA_W-1:0]   raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] rf_r [NREGS];

    // Storage update; writes to r0 are dropped so it stays at its reset zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != {RA_W{1'b0}})) begin
            rf_r[waddr] <= wdata;
        end else begin
            rf_r <= rf_r;
        end
    end

    assign rdata1   = (raddr1   == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rf_r[raddr1];
    assign rdata2   = (raddr2   == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rf_r[raddr2];
    assign dbg_data = (dbg_addr == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rf_r[dbg_addr];

endmodule

// File: rtl/alu_regfile_stage.sv
// Operand-issue / writeback stage in front of a combinational ALU: reads
// operands (with one-deep forwarding), holds the EX register, writes back G.
module alu_regfile_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic              hold,
    output logic [3:0]        alu_G_sel,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    input  logic [DATA_W-1:0] alu_G,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal_op,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [RA_W-1:0]   ex_rd_r;
    logic              ex_valid_r;
    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [3:0]        op_sel_s;
    logic              issue_s;
    logic              legal_s;
    logic              wb_en_s;
    logic              fwd1_s;
    logic              fwd2_s;

    assign in_ready = ~hold;
    assign issue_s  = in_valid & ~hold;
    assign legal_s  = in_imm_en | is_legal_op(in_op);
    assign wb_en_s  = ex_valid_r & ~hold;

    // The EX result is written on the same edge a dependent reads, so the
    // register-file value would be stale; take alu_G instead.
    assign fwd1_s = ex_valid_r & (ex_rd_r == in_rs1) & (in_rs1 != {RA_W{1'b0}});
    assign fwd2_s = ex_valid_r & (ex_rd_r == in_rs2) & (in_rs2 != {RA_W{1'b0}});

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .RA_W   (RA_W)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en_s),
        .waddr    (ex_rd_r),
        .wdata    (alu_G),
        .raddr1   (in_rs1),
        .rdata1   (rs1_data_s),
        .raddr2   (in_rs2),
        .rdata2   (rs2_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Operand and op select: immediate beats forwarded result beats register file.
    always_comb begin
        op_sel_s = in_op;
        op_a_s   = rs1_data_s;
        op_b_s   = rs2_data_s;
        if (in_imm_en) begin
            op_sel_s = ADD;
            op_a_s   = in_imm;
            op_b_s   = {DATA_W{1'b0}};
        end else begin
            if (fwd1_s) begin
                op_a_s = alu_G;
            end else begin
                op_a_s = rs1_data_s;
            end
            if (fwd2_s) begin
                op_b_s = alu_G;
            end else begin
                op_b_s = rs2_data_s;
            end
        end
    end

    // EX register: loads on a legal issue, freezes under hold, else empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_rd_r    <= {RA_W{1'b0}};
            alu_G_sel  <= 4'b0000;
            alu_A      <= {DATA_W{1'b0}};
            alu_B      <= {DATA_W{1'b0}};
            illegal_op <= 1'b0;
        end else begin
            if (hold) begin
                ex_valid_r <= ex_valid_r;
            end else if (issue_s && legal_s) begin
                ex_valid_r <= 1'b1;
                ex_rd_r    <= in_rd;
                alu_G_sel  <= op_sel_s;
                alu_A      <= op_a_s;
                alu_B      <= op_b_s;
            end else begin
                ex_valid_r <= 1'b0;
            end
            if (issue_s && !legal_s) begin
                illegal_op <= 1'b1;
            end else begin
                illegal_op <= illegal_op;
            end
        end
    end

    // Writeback reporting and flag latch for the instruction leaving EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags    <= 4'b0000;
            wb_valid <= 1'b0;
            wb_rd    <= {RA_W{1'b0}};
            wb_data  <= {DATA_W{1'b0}};
        end else if (wb_en_s) begin
            flags    <= alu_flags;
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd_r;
            wb_data  <= alu_G;
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_regfile_stage.sv
// Bench for alu_regfile_stage: a combinational ALU closes the loop, and an
// instruction-level reference model predicts writebacks, flags and rf contents.
module tb_alu_regfile_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_imm_en;
    logic [31:0] in_imm;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        hold;
    logic [3:0]  alu_G_sel;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [31:0] alu_G;
    logic [3:0]  alu_flags;
    logic [3:0]  flags;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_op;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_regfile_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .hold       (hold),
        .alu_G_sel  (alu_G_sel),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_G      (alu_G),
        .alu_flags  (alu_flags),
        .flags      (flags),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .illegal_op (illegal_op),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ALU between the stage's outputs and its alu_G/alu_flags inputs.
    logic [32:0] alu_sum;
    logic        alu_v;
    always_comb begin
        alu_sum = 33'd0;
        alu_v   = 1'b0;
        case (alu_G_sel)
            ADD: begin
                alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
                alu_v   = (alu_A[31] == alu_B[31]) && (alu_sum[31] != alu_A[31]);
            end
            SUB: begin
                alu_sum = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
                alu_v   = (alu_A[31] != alu_B[31]) && (alu_sum[31] != alu_A[31]);
            end
            XOR:     alu_sum = {1'b0, alu_A ^ alu_B};
            OR:      alu_sum = {1'b0, alu_A | alu_B};
            AND:     alu_sum = {1'b0, alu_A & alu_B};
            default: alu_sum = 33'd0;
        endcase
        alu_G     = alu_sum[31:0];
        alu_flags = {(alu_sum[31:0] == 32'd0), alu_sum[32], alu_sum[31], alu_v};
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: arch_rf is the program-order view, com_rf what is in the rf.
    logic [31:0] arch_rf [8];
    logic [31:0] com_rf  [8];
    logic [3:0]  m_flags;
    bit          m_ill;
    bit          p_vld;
    logic [2:0]  p_rd;
    logic [31:0] p_data;
    logic [3:0]  p_fl;

    function automatic void model_exec(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] r,
                                       output logic [3:0] f);
        longint s;
        f = 4'b0000;
        s = 0;
        case (op)
            ADD: begin
                r = a + b;
                f[C_BIT] = (r < a);
                s = longint'($signed(a)) + longint'($signed(b));
            end
            SUB: begin
                r = a - b;
                f[C_BIT] = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
            end
            XOR:     r = a ^ b;
            OR:      r = a | b;
            AND:     r = a & b;
            default: r = 32'd0;
        endcase
        f[V_BIT] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        f[Z_BIT] = (r == 32'd0);
        f[N_BIT] = r[31];
    endfunction

    function automatic bit op_ok(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b1000) ||
               (op == 4'b1100) || (op == 4'b1110);
    endfunction

    task automatic drive(input bit v, input bit ie, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm,
                         input bit h, input logic [2:0] dbg);
        in_valid  = v;
        in_imm_en = ie;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        hold      = h;
        dbg_addr  = dbg;
    endtask

    // One clock: advance the model over the edge, then compare everything observable.
    task automatic tick();
        bit          exp_wb;
        logic [2:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  op;
        @(posedge clk);
        exp_wb = 1'b0;
        e_rd   = 3'd0;
        e_data = 32'd0;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                arch_rf[i] = 32'd0;
                com_rf[i]  = 32'd0;
            end
            m_flags = 4'b0000;
            m_ill   = 1'b0;
            p_vld   = 1'b0;
        end else if (!hold) begin
            if (p_vld) begin
                exp_wb  = 1'b1;
                e_rd    = p_rd;
                e_data  = p_data;
                m_flags = p_fl;
                if (p_rd != 3'd0) com_rf[p_rd] = p_data;
            end
            p_vld = 1'b0;
            if (in_valid) begin
                if (in_imm_en) begin
                    a  = in_imm;
                    b  = 32'd0;
                    op = 4'b0000;
                end else begin
                    a  = arch_rf[in_rs1];
                    b  = arch_rf[in_rs2];
                    op = in_op;
                end
                if (in_imm_en || op_ok(in_op)) begin
                    model_exec(op, a, b, r, f);
                    p_vld = 1'b1;
                    p_rd  = in_rd;
                    p_data = r;
                    p_fl  = f;
                    if (in_rd != 3'd0) arch_rf[in_rd] = r;
                end else begin
                    m_ill = 1'b1;
                end
            end
        end
        #1;
        check_val("in_ready", {31'd0, in_ready}, {31'd0, ~hold});
        check_val("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wb});
        if (exp_wb) begin
            check_val("wb_rd", {29'd0, wb_rd}, {29'd0, e_rd});
            check_val("wb_data", wb_data, e_data);
        end
        check_val("flags", {28'd0, flags}, {28'd0, m_flags});
        check_val("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
        check_val("dbg_data", dbg_data, com_rf[dbg_addr]);
        if (rst) begin
            check_val("rst_alu_A", alu_A, 32'd0);
            check_val("rst_alu_B", alu_B, 32'd0);
            check_val("rst_G_sel", {28'd0, alu_G_sel}, 32'd0);
        end
    endtask

    initial begin
        logic [3:0] legal_ops [5];
        legal_ops[0] = 4'b0000;
        legal_ops[1] = 4'b0001;
        legal_ops[2] = 4'b1000;
        legal_ops[3] = 4'b1100;
        legal_ops[4] = 4'b1110;

        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        tick();
        tick();
        rst = 1'b0;

        // r1=5, r2=3, r3=r1-r2
        drive(1'b1, 1'b1, 4'b0000, 3'd1, 3'd0, 3'd0, 32'd5, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b1, 4'b0000, 3'd2, 3'd0, 3'd0, 32'd3, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 4'b0001, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd3);
        tick();
        check_val("sub_wb_rd", {29'd0, wb_rd}, 32'd3);
        check_val("sub_wb_data", wb_data, 32'd2);
        check_val("sub_flags", {28'd0, flags}, 32'h4);
        check_val("sub_dbg_r3", dbg_data, 32'd2);

        // Back-to-back dependency through forwarding
        drive(1'b1, 1'b1, 4'b0000, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 4'b0000, 3'd1, 3'd1, 3'd1, 32'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd1);
        tick();
        check_val("fwd_wb_data", wb_data, 32'hFFFF_FFFE);
        check_val("fwd_flags", {28'd0, flags}, 32'h3);

        // XOR to zero
        drive(1'b1, 1'b1, 4'b0000, 3'd4, 3'd0, 3'd0, 32'hA5A5_A5A5, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 4'b1000, 3'd5, 3'd4, 3'd4, 32'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd5);
        tick();
        check_val("xor_wb_data", wb_data, 32'd0);
        check_val("xor_dbg_r5", dbg_data, 32'd0);

        // Illegal op 0101: sticky flag, no writeback
        drive(1'b1, 1'b0, 4'b0101, 3'd2, 3'd1, 3'd1, 32'd0, 1'b0, 3'd2);
        tick();
        check_val("ill_set", {31'd0, illegal_op}, 32'd1);
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd2);
        tick();
        check_val("ill_no_wb", {31'd0, wb_valid}, 32'd0);
        check_val("ill_r2_kept", dbg_data, 32'd3);

        // Hold for three cycles with ADD r6=r1+r2 in EX
        drive(1'b1, 1'b1, 4'b0000, 3'd1, 3'd0, 3'd0, 32'd5, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 4'b0000, 3'd6, 3'd1, 3'd2, 32'd0, 1'b0, 3'd6);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'b0001, 3'd7, 3'd1, 3'd1, 32'd0, 1'b1, 3'd6);
            tick();
            check_val("hold_ready", {31'd0, in_ready}, 32'd0);
            check_val("hold_no_wb", {31'd0, wb_valid}, 32'd0);
        end
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd6);
        tick();
        check_val("hold_wb_data", wb_data, 32'd8);
        check_val("hold_dbg_r6", dbg_data, 32'd8);

        // Write to r0
        drive(1'b1, 1'b0, 4'b0000, 3'd0, 3'd1, 3'd2, 32'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd0);
        tick();
        check_val("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_val("r0_wb_data", wb_data, 32'd8);
        check_val("r0_dbg", dbg_data, 32'd0);

        // Reset while an ADD sits in EX
        drive(1'b1, 1'b0, 4'b0000, 3'd7, 3'd1, 3'd2, 32'd0, 1'b0, 3'd7);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 3'd7);
        tick();
        rst = 1'b0;
        tick();
        check_val("rst_no_wb", {31'd0, wb_valid}, 32'd0);
        check_val("rst_dbg_r7", dbg_data, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] imm;
            logic [3:0]  op;
            case ($urandom_range(0, 3))
                0:       imm = 32'h7FFF_FFFF;
                1:       imm = 32'h8000_0000;
                default: imm = $urandom;
            endcase
            if ($urandom_range(0, 99) < 88) op = legal_ops[$urandom_range(0, 4)];
            else                             op = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 25, op,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  imm, $urandom_range(0, 99) < 15, 3'($urandom_range(0, 7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_regfile_stage.md
Name: alu_regfile_stage

Overview:
- Operand-issue and writeback stage that sits directly upstream of the combinational ALU.
- Accepts one instruction per cycle over a valid/ready handshake, reads two operands from an internal register file, and holds them in an EX register that drives the ALU's G_sel/A/B inputs.
- On the next edge it writes the ALU result G into the destination register and latches the ZCNV flags.
- A one-deep result-forwarding path removes back-to-back dependency stalls.

Parameters:
- DATA_W, 32, operand/result width (must match the ALU instance).
- NREGS, 8, register-file depth (power of 2, at least 2).
- RA_W, 3, register address width = log2(NREGS).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept; equals !hold
- in_op  in  4  ALU op code; legal values are ADD=0000, SUB=0001, XOR=1000, OR=1100, AND=1110
- in_imm_en  in  1  immediate load: rd <= in_imm, executed as ADD with A=in_imm, B=0; in_op and rs fields are ignored
- in_imm  in  DATA_W  immediate value
- in_rd, in_rs1, in_rs2  in  RA_W each  destination and source register addresses
- hold  in  1  freeze the pipeline
- alu_G_sel  out  4  to ALU G_sel (registered)
- alu_A, alu_B  out  DATA_W each  to ALU A and B (registered)
- alu_G  in  DATA_W  from ALU result
- alu_flags  in  4  from ALU ZCNVFlags; bit3=Z, bit2=C, bit1=N, bit0=V
- flags  out  4  last latched ZCNV value
- wb_valid  out  1  one-cycle pulse, a register write occurred at this edge
- wb_rd  out  RA_W  register written
- wb_data  out  DATA_W  value written
- illegal_op  out  1  sticky; set when an illegal op is accepted
- dbg_addr  in  RA_W  debug read address
- dbg_data  out  DATA_W  combinational read of rf[dbg_addr]; r0 always reads 0

Behaviour:
- Reset: rf all zero, ex_valid=0, alu_G_sel/alu_A/alu_B=0, flags=0, wb_valid=0, wb_rd=0, wb_data=0, illegal_op=0. An in-flight EX instruction is discarded and causes no write.
- Register r0 reads as 0 everywhere. Writes to r0 still pulse wb_valid and update flags, but rf[0] is unchanged.
- Issue (edge where in_valid && in_ready):
  - EX regs load G_sel (0000 if in_imm_en), A, B, ex_rd; ex_valid <= 1.
  - With no valid issue, ex_valid <= 0 and alu_A/B/G_sel hold their values.
- Operand read uses the priority: imm > forward > rf.
  - Forward: if ex_valid && ex_rd == rs && rs != 0, the operand is alu_G (the current EX result).
  - Otherwise the operand is rf[rs].
- Illegal op, non-immediate: the instruction is accepted (in_ready unaffected), illegal_op is set, and no EX entry is created. It produces no write and no flag change.
- Writeback, at each edge with ex_valid && !hold:
  - rf[ex_rd] <= alu_G.
  - flags <= alu_flags.
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_G.
  - Otherwise wb_valid <= 0.
- Latency: an instruction accepted at edge N has its result in rf, wb_*, and flags at edge N+1. Dependent issue at N+1 receives the correct value via forwarding, so there are no bubbles.
- Hold: EX regs, rf, and flags are frozen; in_ready=0; wb_valid <= 0. The ALU sees stable inputs; the write completes on the first edge after hold falls.
- Simultaneous writeback and read of the same rf entry at one edge: the reader gets the forwarded alu_G, never the stale rf value.
- Logic ops latch whatever flags the ALU reports; this stage does not reinterpret them.

Decomposition:
- Shared package alu_pkg: op-code constants ADD/SUB/XOR/OR/AND, flag bit indices Z_BIT=3, C_BIT=2, N_BIT=1, V_BIT=0, and an is_legal_op function.
- One natural sub-module: alu_regfile, NREGS x DATA_W with 2 combinational read ports + 1 debug read port, 1 synchronous write port, r0 hardwired zero.
- The top stage contains the EX register, forwarding muxes, and writeback/flag logic.
- The bench instantiates the ALU between the alu_* outputs and alu_G/alu_flags.

Test Plan:
- Reset then load r1=5, r2=3 via imm, then SUB r3=r1-r2 -> at edge after SUB, wb_rd=3, wb_data=2; dbg r3=2; flags=0100 (C=1 from borrow-free subtract).
- Back-to-back forward: imm r1=0x7FFFFFFF; ADD r1=r1+r1 issued next cycle -> wb_data=0xFFFFFFFE, flags=0011 (N=1, V=1), no stall.
- Zero result: imm r4=0xA5A5A5A5; XOR r5=r4^r4 -> wb_data=0, rf[5]=0.
- Illegal op 0101 with valid=1 -> illegal_op=1 (sticky), no wb_valid, flags unchanged, next legal op still executes.
- Hold: issue ADD r6=r1+r2 (r1=5, r2=3), then assert hold for 3 cycles -> in_ready=0, wb_valid=0 during hold; wb_data=8 on the first edge after release.
- Write to r0: ADD r0=r1+r2 -> wb_valid=1 and flags update, but dbg_addr=0 reads 0. Assert rst while an ADD is in EX -> no write, all outputs 0 next cycle.
